// File: rtl/mul_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mul_pkg
// Description : Shared widths and state encoding for the sequential multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

    localparam int MUL_W     = 16;
    localparam int MUL_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage : mul_pkg
`default_nettype wire

// File: rtl/FastAdder_16.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : FastAdder_16
// Description : 16-bit carry-lookahead adder, four 4-bit groups with a
//               lookahead carry unit across the groups.
// Revision    : 1.0 - initial release
// ============================================================================
module FastAdder_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] w_g;
    logic [15:0] w_p;
    logic [15:0] w_c;
    logic [3:0]  w_gg;
    logic [3:0]  w_gp;
    logic [3:0]  w_cg;

    assign w_g = a & b;
    assign w_p = a ^ b;

    genvar k, j;
    generate
        for (k = 0; k < 4; k++) begin : g_grp
            assign w_gg[k] = w_g[4*k+3]
                           | (w_p[4*k+3] & w_g[4*k+2])
                           | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                           | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
            assign w_gp[k] = &w_p[4*k+3:4*k];
            assign w_c[4*k] = w_cg[k];
            for (j = 0; j < 3; j++) begin : g_bit
                assign w_c[4*k+j+1] = w_g[4*k+j] | (w_p[4*k+j] & w_c[4*k+j]);
            end
        end
    endgenerate

    // Group carries resolved in parallel so the ripple stays inside 4 bits.
    assign w_cg[0] = cin;
    assign w_cg[1] = w_gg[0] | (w_gp[0] & cin);
    assign w_cg[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & cin);
    assign w_cg[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[2] & w_gp[1] & w_gp[0] & cin);
    assign cout    = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & cin);

    assign sum = w_p ^ w_c;

endmodule : FastAdder_16
`default_nettype wire

// File: rtl/mul_seq_16.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mul_seq_16
// Description : 16x16 unsigned shift-add multiplier, one partial product per
//               cycle, valid/ready handshakes on operand and result sides.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_seq_16
    import mul_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [MUL_W-1:0]     a,
    input  logic [MUL_W-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*MUL_W-1:0]   product
);

    mul_state_t           r_state;
    mul_state_t           w_state_nxt;
    logic [MUL_W-1:0]     r_mcand;
    logic [MUL_W-1:0]     r_acc;
    logic [MUL_W-1:0]     r_mq;
    logic [MUL_CNT_W-1:0] r_cnt;
    logic [MUL_W-1:0]     w_addend;
    logic [MUL_W-1:0]     w_sum;
    logic                 w_cout;

    assign w_addend = r_mq[0] ? r_mcand : '0;

    FastAdder_16 u_add (
        .a    (r_acc),
        .b    (w_addend),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_comb begin
        w_state_nxt = IDLE;
        case (r_state)
            IDLE:    w_state_nxt = in_valid ? RUN : IDLE;
            RUN:     w_state_nxt = (r_cnt == {MUL_CNT_W{1'b1}}) ? DONE : RUN;
            DONE:    w_state_nxt = out_ready ? IDLE : DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_mcand <= '0;
            r_acc   <= '0;
            r_mq    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && in_valid) begin
                r_mcand <= a;
                r_mq    <= b;
                r_acc   <= '0;
                r_cnt   <= '0;
            end else if (r_state == RUN) begin
                // 33-bit right shift of {cout, sum, mq}: the retired multiplier
                // bit leaves while the new product bit enters mq from the top.
                {r_acc, r_mq} <= {w_cout, w_sum, r_mq[MUL_W-1:1]};
                r_cnt         <= r_cnt + 1'b1;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign product   = {r_acc, r_mq};

endmodule : mul_seq_16
`default_nettype wire
